game_fsm: RTL and testbench
===========================

# game_fsm

Top-level battle sequencer and the initiator side of the phase handshake. It drives the 4-bit game state and turn number consumed by the enemy pattern block and the other phase blocks, and advances between phases on their busy/finished responses. It sits between the input/camera front end and the per-phase renderers, and owns the single authoritative `state` and `turn` registers.

## Interface
**Parameters**
- `NUM_TURNS`, default 8: number of enemy phases that must be survived to win.
- `TIMEOUT_CYCLES`, default 27'd100_000_000: enemy-phase watchdog limit in clk cycles. Used only with the watchdog compiled in.

**Ports**
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `start_in`, input, 1: one-cycle pulse that starts or restarts a game.
- `confirm_in`, input, 1: one-cycle pulse that confirms the current menu or dialog.
- `menu_sel_in`, input, 2: menu choice. 0 = FIGHT, 1-3 = non-attack options.
- `attack_done_in`, input, 1: one-cycle pulse from the attack phase when it completes.
- `enemy_hp_zero_in`, input, 1: level signal; the enemy is defeated.
- `player_hp_zero_in`, input, 1: level signal; the player is dead.
- `enemy_busy_in`, input, 1: busy level from the enemy block.
- `enemy_finished_in`, input, 1: one-cycle finished pulse from the enemy block.
- `state_out`, output, 4: current state encoding. Reset value 4'h0.
- `turn_out`, output, 4: completed enemy turns. Reset value 0.
- `phase_start_out`, output, 1: one-cycle pulse on the first cycle of every new state. Reset value 0.
- `timeout_out`, output, 1: one-cycle pulse when the watchdog forces phase end. Reset value 0.

## Operation
**State encodings**
- IDLE 4'h0, MENU 4'h1, ATTACK 4'h2, DIALOG 4'h4, ENEMY 4'h8, WIN 4'hE, LOSE 4'hF.

**Transitions**
- IDLE: on `start_in`, go to MENU and clear `turn`.
- MENU: on `confirm_in`, go to ATTACK if `menu_sel_in`==0, otherwise go to DIALOG.
- ATTACK: on `attack_done_in`, go to WIN if `enemy_hp_zero_in`, otherwise go to ENEMY.
- DIALOG: on `confirm_in`, go to ENEMY.
- ENEMY: on an accepted finish, increment `turn`. Then go to WIN if the new turn equals `NUM_TURNS`, otherwise go to MENU.
- Any non-terminal state: `player_hp_zero_in` high goes to LOSE. This has priority over every other transition.
- WIN / LOSE: on `start_in`, go to IDLE.

**ENEMY handshake**
- A `seen_busy` flag clears on entry to ENEMY and sets when `enemy_busy_in` is high.
- `enemy_finished_in` is accepted only while `seen_busy`=1, or in the same cycle that busy is first seen. Stale finished pulses from a previous phase are ignored.

**Input qualification**
- `start_in` is ignored outside IDLE, WIN and LOSE.
- `confirm_in` is ignored outside MENU and DIALOG.
- `turn` saturates and never wraps: it stops at `NUM_TURNS`.

## Timing
- All outputs are registered.
- A qualifying input sampled at edge N changes `state_out` after edge N. Latency is 1 cycle.
- `phase_start_out` is high during the first cycle in which `state_out` shows the new value.
- `turn_out` updates on the same edge that leaves ENEMY.
- Simultaneous `enemy_finished_in` and `player_hp_zero_in` give LOSE, with `turn` unchanged.
- Simultaneous `confirm_in` and `start_in` in MENU: confirm wins, start is ignored.
- `rst` mid-phase returns to IDLE the next cycle: all outputs at reset values, `seen_busy` and watchdog cleared.

## Configuration
- Macro `GAME_FSM_WATCHDOG_EN`.
- **Defined:** a counter runs while in ENEMY and clears on entry.
  - When it reaches `TIMEOUT_CYCLES`-1 with no accepted finish, the FSM treats it as an accepted finish.
  - `timeout_out` pulses for 1 cycle, coincident with the transition edge.
  - `player_hp_zero_in` still has priority.
- **Undefined:** ENEMY waits indefinitely for a finish, `timeout_out` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `game_pkg`, which all phase blocks import:
  - a `game_state_t` enum with the encodings above;
  - `MENU_FIGHT` = 2'd0.
- One sub-module, `phase_watchdog`, instantiated only under the macro:
  - inputs: clk, rst, clear, enable;
  - output: expired pulse;
  - parameter: `TIMEOUT_CYCLES`.

## Test plan
- Reset, then `start_in`: `state_out` goes 0→1, `phase_start_out` pulses once, `turn_out`=0.
- MENU, `menu_sel_in`=0, confirm → ATTACK. Then `attack_done_in` with `enemy_hp_zero_in`=1 → `state_out`=4'hE.
- ENEMY entered, `enemy_finished_in` pulsed before any busy → stays 4'h8. Then busy high 3 cycles followed by finished → MENU, `turn_out`=1.
- `NUM_TURNS`=2, run two full DIALOG→ENEMY rounds → WIN after the second finish, `turn_out`=2.
- Same-cycle finish and `player_hp_zero_in` in ENEMY → 4'hF, `turn_out` unchanged. `rst` asserted mid-ENEMY → 4'h0 next cycle.
- With the macro and `TIMEOUT_CYCLES`=16, busy held with no finish → `timeout_out` pulses on cycle 16 after entry and the FSM moves to MENU. Without the macro, it stays in ENEMY for 1000 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared battle-state encodings and menu constants for all phase blocks
package game_pkg;
  typedef enum logic [3:0] {
    IDLE   = 4'h0,
    MENU   = 4'h1,
    ATTACK = 4'h2,
    DIALOG = 4'h4,
    ENEMY  = 4'h8,
    WIN    = 4'hE,
    LOSE   = 4'hF
  } game_state_t;
  localparam logic [1:0] MENU_FIGHT = 2'd0;
endpackage

// File: rtl/game_fsm_phase_watchdog.sv
// phase_watchdog: counts enabled cycles and flags the one on which TIMEOUT_CYCLES is reached
module phase_watchdog #(
  parameter logic [26:0] TIMEOUT_CYCLES = 27'd100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [26:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : enable ? cnt_q + 27'd1 : cnt_q;
  assign expired = enable & ~clear & (cnt_q == TIMEOUT_CYCLES - 27'd1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_fsm.sv
// game_fsm: battle sequencer owning state/turn; enemy watchdog enabled by GAME_FSM_WATCHDOG_EN
module game_fsm import game_pkg::*; #(
  parameter int          NUM_TURNS      = 8,
  parameter logic [26:0] TIMEOUT_CYCLES = 27'd100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       confirm_in,
  input  logic [1:0] menu_sel_in,
  input  logic       attack_done_in,
  input  logic       enemy_hp_zero_in,
  input  logic       player_hp_zero_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic       phase_start_out,
  output logic       timeout_out
);
  localparam logic [3:0] S_IDLE   = IDLE;
  localparam logic [3:0] S_MENU   = MENU;
  localparam logic [3:0] S_ATTACK = ATTACK;
  localparam logic [3:0] S_DIALOG = DIALOG;
  localparam logic [3:0] S_ENEMY  = ENEMY;
  localparam logic [3:0] S_WIN    = WIN;
  localparam logic [3:0] S_LOSE   = LOSE;
  logic [3:0] state_q, state_d, turn_q, turn_d, turn_inc;
  logic seen_q, seen_d, ps_q, to_q, to_d;
  logic in_enemy, terminal, fin_ok, expired;
  assign in_enemy = state_q == S_ENEMY;
  assign terminal = (state_q == S_WIN) || (state_q == S_LOSE);
  // a finish counts only once this phase has shown busy, so stale pulses are dropped
  assign fin_ok = in_enemy & enemy_finished_in & (seen_q | enemy_busy_in);
  assign seen_d = in_enemy & (seen_q | enemy_busy_in);
  assign turn_inc = (turn_q == 4'(NUM_TURNS)) ? turn_q : turn_q + 4'd1;
  assign to_d = expired & ~fin_ok & ~player_hp_zero_in;
`ifdef GAME_FSM_WATCHDOG_EN
  phase_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (~in_enemy),
    .enable (in_enemy),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    turn_d = turn_q;
    if (!terminal && player_hp_zero_in) state_d = S_LOSE;
    else begin
      case (state_q)
        S_IDLE: if (start_in) begin
          state_d = S_MENU;
          turn_d = '0;
        end
        S_MENU: if (confirm_in) state_d = (menu_sel_in == MENU_FIGHT) ? S_ATTACK : S_DIALOG;
        S_ATTACK: if (attack_done_in) state_d = enemy_hp_zero_in ? S_WIN : S_ENEMY;
        S_DIALOG: if (confirm_in) state_d = S_ENEMY;
        S_ENEMY: if (fin_ok | expired) begin
          turn_d = turn_inc;
          state_d = (turn_inc == 4'(NUM_TURNS)) ? S_WIN : S_MENU;
        end
        S_WIN, S_LOSE: if (start_in) state_d = S_IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      turn_q <= '0;
      seen_q <= 1'b0;
      ps_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q <= turn_d;
      seen_q <= seen_d;
      ps_q <= state_d != state_q;
      to_q <= to_d;
    end
  end
  assign state_out = state_q;
  assign turn_out = turn_q;
  assign phase_start_out = ps_q;
  assign timeout_out = to_q;
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed and random stimulus against an in-bench behavioural model of the sequencer
module tb_game_fsm;
  localparam int N = 2;
  localparam logic [26:0] T = 27'd16;
`ifdef GAME_FSM_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, confirm = 0, ad = 0, ehp = 0, php = 0, busy = 0, fin = 0;
  logic [1:0] sel = 0;
  logic [3:0] st, tn;
  logic ps, to;
  int checks = 0, passed = 0;
  bit chk_en = 0;
  int m_state = 0, m_turn = 0, m_ecyc = 0;
  bit m_ps = 0, m_to = 0, m_seen = 0;

  game_fsm #(.NUM_TURNS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start_in(start), .confirm_in(confirm), .menu_sel_in(sel),
    .attack_done_in(ad), .enemy_hp_zero_in(ehp), .player_hp_zero_in(php),
    .enemy_busy_in(busy), .enemy_finished_in(fin),
    .state_out(st), .turn_out(tn), .phase_start_out(ps), .timeout_out(to)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    else passed++;
  endtask

  // model: phase rules written as plain priority of events over the encodings
  always @(posedge clk) begin
    int nxt;
    bit acc, wd, to_n;
    if (rst) begin
      m_state = 0; m_turn = 0; m_ps = 0; m_to = 0; m_seen = 0; m_ecyc = 0;
    end else begin
      nxt = m_state;
      to_n = 0;
      acc = (m_state == 8) && fin && (m_seen || busy);
      wd = WD && (m_state == 8) && (m_ecyc == int'(T) - 1);
      if (m_state < 14 && php) nxt = 15;
      else if (m_state == 0 && start) begin nxt = 1; m_turn = 0; end
      else if (m_state == 1 && confirm) nxt = (sel == 0) ? 2 : 4;
      else if (m_state == 2 && ad) nxt = ehp ? 14 : 8;
      else if (m_state == 4 && confirm) nxt = 8;
      else if (m_state == 8 && (acc || wd)) begin
        m_turn = (m_turn < N) ? m_turn + 1 : N;
        nxt = (m_turn == N) ? 14 : 1;
        to_n = !acc;
      end
      else if (m_state >= 14 && start) nxt = 0;
      m_ps = nxt != m_state;
      m_to = to_n;
      if (m_state == 8 && nxt == 8) begin m_seen = m_seen || busy; m_ecyc++; end
      else begin m_seen = 0; m_ecyc = 0; end
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", st, m_state);
      check("turn", tn, m_turn);
      check("phase_start", ps, m_ps);
      check("timeout", to, m_to);
    end
  end

  task automatic step();
    @(negedge clk);
    start = 0; confirm = 0; ad = 0; fin = 0;
  endtask

  initial begin
    int n;
    step(); chk_en = 1; step();
    rst = 0;
    check("lit_rst_state", st, 4'h0); check("lit_rst_turn", tn, 0);
    check("lit_rst_ps", ps, 0); check("lit_rst_to", to, 0);
    start = 1; step();
    check("lit_start_state", st, 4'h1); check("lit_start_ps", ps, 1); check("lit_start_turn", tn, 0);
    step(); check("lit_ps_once", ps, 0);
    sel = 0; confirm = 1; step(); check("lit_fight", st, 4'h2);
    ad = 1; ehp = 1; step(); check("lit_attack_win", st, 4'hE); ehp = 0;
    start = 1; step(); start = 1; step();
    sel = 1; confirm = 1; step(); check("lit_dialog", st, 4'h4);
    confirm = 1; step(); check("lit_enemy", st, 4'h8);
    fin = 1; step(); check("lit_stale_fin", st, 4'h8);
    busy = 1; step(); step(); step(); busy = 0; fin = 1; step();
    check("lit_fin_menu", st, 4'h1); check("lit_turn1", tn, 1);
    confirm = 1; step(); confirm = 1; step(); busy = 1; step(); busy = 0; fin = 1; step();
    check("lit_win_turns", st, 4'hE); check("lit_turn2", tn, 2);
    start = 1; step(); start = 1; step(); check("lit_turn_clear", tn, 0);
    confirm = 1; step(); confirm = 1; step(); busy = 1; step(); busy = 0; fin = 1; step();
    confirm = 1; step(); confirm = 1; step(); busy = 1; step(); busy = 0; fin = 1; php = 1; step(); php = 0;
    check("lit_lose", st, 4'hF); check("lit_lose_turn", tn, 1);
    start = 1; step(); start = 1; step(); confirm = 1; step(); confirm = 1; step();
    busy = 1; step(); rst = 1; step(); rst = 0; busy = 0;
    check("lit_midrst_state", st, 4'h0); check("lit_midrst_turn", tn, 0); check("lit_midrst_ps", ps, 0);
    start = 1; step(); confirm = 1; step(); confirm = 1; step(); busy = 1;
    n = 1;
    while (n < 1000) begin
      step();
      if (st != 4'h8) break;
      n++;
    end
`ifdef GAME_FSM_WATCHDOG_EN
    check("lit_wd_cycles", n, 16); check("lit_wd_state", st, 4'h1); check("lit_wd_pulse", to, 1);
    step(); check("lit_wd_pulse_end", to, 0);
`else
    check("lit_nowd_cycles", n, 1000); check("lit_nowd_state", st, 4'h8); check("lit_nowd_to", to, 0);
`endif
    busy = 0; rst = 1; step(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      confirm = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 5) == 0);
      ehp = ($urandom_range(0, 3) == 0);
      php = ($urandom_range(0, 39) == 0);
      busy = ($urandom_range(0, 2) == 0);
      fin = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 0; php = 0; busy = 0; ehp = 0;
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
